// File: rtl/pipo_pkg.sv
// Shared constants for the pipo_reg capture/holding register.
// Optional clock enable is selected with the PIPO_CE_EN macro.
package pipo_pkg;
    localparam int PIPO_MAX_DEPTH = 16;
    localparam int PIPO_DEF_WIDTH = 8;
endpackage

// File: rtl/pipo_stage.sv
// One WIDTH-bit register with synchronous active-low reset.
// Defining PIPO_CE_EN adds a clock-enable input `ce`; reset still wins when ce is low.
module pipo_stage
    import pipo_pkg::*;
#(
    parameter int               WIDTH   = PIPO_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PIPO_CE_EN
    input  logic             ce,
`endif
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
`ifdef PIPO_CE_EN
        if (ce) begin
            data_d = d;
        end
`else
        data_d = d;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipo_reg.sv
// Parallel-in/parallel-out register with a DEPTH-stage pipeline (latency = DEPTH clocks).
// Defining PIPO_CE_EN adds a `ce` port that freezes the whole pipeline when low.
module pipo_reg
    import pipo_pkg::*;
#(
    parameter int               WIDTH   = PIPO_DEF_WIDTH,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
`ifdef PIPO_CE_EN
    input  logic             ce,
`endif
    input  logic [WIDTH-1:0] si,
    output logic [WIDTH-1:0] so
);

    generate
        if (DEPTH < 1 || DEPTH > PIPO_MAX_DEPTH) begin : g_bad_depth
            $fatal(1, "pipo_reg: DEPTH=%0d outside legal range 1..%0d", DEPTH, PIPO_MAX_DEPTH);
        end
    endgenerate

    // stage_in[k] feeds stage k; stage_out[k] is its registered output
    logic [DEPTH-1:0][WIDTH-1:0] stage_in;
    logic [DEPTH-1:0][WIDTH-1:0] stage_out;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign stage_in[k] = si;
            end else begin : g_rest
                assign stage_in[k] = stage_out[k-1];
            end

            pipo_stage #(
                .WIDTH   (WIDTH),
                .RST_VAL (RST_VAL)
            ) u_stage (
                .clk (clk),
                .rst (rst),
`ifdef PIPO_CE_EN
                .ce  (ce),
`endif
                .d   (stage_in[k]),
                .q   (stage_out[k])
            );
        end
    endgenerate

    assign so = stage_out[DEPTH-1];

endmodule

// File: tb/tb_pipo_reg.sv
// Self-checking bench for pipo_reg: DEPTH=1 and DEPTH=3 instances share stimulus
// and are compared against queue-based delay-line models.
module tb_pipo_reg;

    logic       clk;
    logic       rst;
    logic [7:0] si;
    logic [7:0] so1;
    logic [7:0] so3;
`ifdef PIPO_CE_EN
    logic       ce;
`endif

    int tests = 0;
    int fails = 0;

    logic [7:0] m1[$];
    logic [7:0] m3[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipo_reg #(.WIDTH(8), .DEPTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
`ifdef PIPO_CE_EN
        .ce  (ce),
`endif
        .si  (si),
        .so  (so1)
    );

    pipo_reg #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk (clk),
        .rst (rst),
`ifdef PIPO_CE_EN
        .ce  (ce),
`endif
        .si  (si),
        .so  (so3)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // delay line: reset refills with zeros, otherwise shift one word per enabled edge
    task automatic model_edge(input logic r, input logic [7:0] d, input logic c);
        if (!r) begin
            m1.delete();
            m3.delete();
            m1.push_back(8'h00);
            repeat (3) m3.push_back(8'h00);
        end else if (c) begin
            m1.push_back(d);
            void'(m1.pop_front());
            m3.push_back(d);
            void'(m3.pop_front());
        end
    endtask

    task automatic step(input string tag, input logic r, input logic [7:0] d, input logic c);
        @(negedge clk);
        rst = r;
        si  = d;
`ifdef PIPO_CE_EN
        ce  = c;
`endif
        @(posedge clk);
        model_edge(r, d, c);
        #1;
        check({tag, "/so1"}, so1, m1[0]);
        check({tag, "/so3"}, so3, m3[0]);
    endtask

    initial begin
        logic       r;
        logic       c;
        logic [7:0] d;
        logic [7:0] w;

        rst = 1'b0;
        si  = 8'hFF;
`ifdef PIPO_CE_EN
        ce  = 1'b1;
`endif

        // reset with all-ones input
        step("rst0", 1'b0, 8'hFF, 1'b1);
        check("rst0_const", so3, 8'h00);
        step("rst1", 1'b0, 8'hFF, 1'b1);
        check("rst1_const", so1, 8'h00);

        // single load, held input
        step("load", 1'b1, 8'b1001_0011, 1'b1);
        check("load_d1", so1, 8'h93);
        check("load_d3_not_yet", so3, 8'h00);
        step("hold", 1'b1, 8'h93, 1'b1);
        check("hold_d1", so1, 8'h93);

        // streaming after reset
        step("srst", 1'b0, 8'h00, 1'b1);
        for (int i = 1; i <= 8; i++) begin
            step("stream", 1'b1, 8'(i), 1'b1);
            if (i <= 2) check("stream_zero", so3, 8'h00);
            else        check("stream_order", so3, 8'(i - 2));
        end

        // reset while A5/5A/3C are in flight
        step("mid_a", 1'b1, 8'hA5, 1'b1);
        step("mid_b", 1'b1, 8'h5A, 1'b1);
        step("mid_c", 1'b1, 8'h3C, 1'b1);
        check("mid_full", so3, 8'hA5);
        step("mid_rst", 1'b0, 8'h77, 1'b1);
        check("mid_rst_out", so3, 8'h00);
        step("mid_p1", 1'b1, 8'h11, 1'b1);
        check("mid_flush1", so3, 8'h00);
        step("mid_p2", 1'b1, 8'h22, 1'b1);
        check("mid_flush2", so3, 8'h00);
        step("mid_p3", 1'b1, 8'h33, 1'b1);
        check("mid_first", so3, 8'h11);

        // walking ones then walking zeros
        for (int i = 0; i < 8; i++) begin
            w = 8'h01 << i;
            step("walk1", 1'b1, w, 1'b1);
            check("walk1_d1", so1, w);
        end
        for (int i = 0; i < 8; i++) begin
            w = ~(8'h01 << i);
            step("walk0", 1'b1, w, 1'b1);
            check("walk0_d1", so1, w);
        end

`ifdef PIPO_CE_EN
        // clock enable freeze, reset under ce=0, resume
        step("ce_l0", 1'b1, 8'h93, 1'b1);
        step("ce_l1", 1'b1, 8'h93, 1'b1);
        step("ce_l2", 1'b1, 8'h93, 1'b1);
        check("ce_loaded", so3, 8'h93);
        step("ce_frz", 1'b1, 8'h6C, 1'b0);
        check("ce_hold", so3, 8'h93);
        step("ce_frz2", 1'b1, 8'h6C, 1'b0);
        check("ce_hold2", so1, 8'h93);
        step("ce_rst", 1'b0, 8'h6C, 1'b0);
        check("ce_rst_out", so3, 8'h00);
        step("ce_r0", 1'b1, 8'h6C, 1'b1);
        step("ce_r1", 1'b1, 8'h6C, 1'b1);
        check("ce_r1_zero", so3, 8'h00);
        step("ce_r2", 1'b1, 8'h6C, 1'b1);
        check("ce_resume", so3, 8'h6C);
`endif

        // randomized traffic with occasional reset (and enable drops when present)
        for (int i = 0; i < 300; i++) begin
            d = 8'($urandom);
            r = ($urandom_range(15) != 0);
`ifdef PIPO_CE_EN
            c = ($urandom_range(3) != 0);
`else
            c = 1'b1;
`endif
            step("rand", r, d, c);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipo_reg.md
Name: pipo_reg

Overview:
- Parallel-in/parallel-out register: captures a WIDTH-bit word on `si` each rising clock and presents it on `so`.
- Optional DEPTH-stage pipeline.
- Used as a capture/holding register in the BIST datapath, e.g. between pattern generator and CUT, or CUT and response analyser.

Parameters:
- WIDTH, 8, data width in bits of `si` and `so`.
- DEPTH, 1, number of register stages from `si` to `so`; legal range 1..16; equals latency in cycles.
- RST_VAL, {WIDTH{1'b0}}, value loaded into every stage on reset.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-low reset.
- si  input  WIDTH  parallel data in.
- so  output  WIDTH  parallel data out; the registered output of the last stage.

Behaviour:
- All state updates on the rising edge of `clk` only. No asynchronous paths. `so` is driven directly from a flop, with no combinational logic from `si`.
- Reset:
  - On a rising edge with `rst == 0`, every stage is loaded with RST_VAL, so `so` = RST_VAL from the next cycle.
  - Reset has priority over data capture and over the clock enable.
- Normal operation (`rst == 1`):
  - stage[0] <= si.
  - stage[k] <= stage[k-1] for k = 1..DEPTH-1.
  - so = stage[DEPTH-1].
- Latency: a word sampled on `si` at edge N appears on `so` after edge N+DEPTH-1 settles, i.e. DEPTH clocks.
- Throughput: one word per cycle. There is no handshake and no back-pressure.
- Reset mid-stream: all in-flight words are discarded. After `rst` returns high, `so` shows RST_VAL until the first post-reset word reaches the output DEPTH clocks later.
- X-handling: `si` is sampled as-is. With `rst` held low for 1 clock, `so` is fully defined regardless of `si`.
- DEPTH outside 1..16 is a compile-time error, raised by a generate-time check.

Optional Feature:
- Macro: PIPO_CE_EN.
- Defined:
  - Adds input port `ce` (1 bit), placed after `rst`.
  - Stages update only on edges where `rst == 1` and `ce == 1`.
  - With `ce == 0`, all stages hold their value; the whole pipeline freezes together.
  - Reset still acts when `ce == 0`.
- Undefined:
  - No `ce` port.
  - Stages update on every non-reset edge, as described under Behaviour.

Decomposition:
- Package `pipo_pkg` holds:
  - PIPO_MAX_DEPTH = 16;
  - default WIDTH constant = 8.
- Sub-module `pipo_stage` is one WIDTH-bit synchronous-reset register, with optional `ce` under PIPO_CE_EN.
- `pipo_reg` instantiates DEPTH copies of `pipo_stage` in a generate loop and adds the parameter-legality check.

Test Plan:
- Reset: hold `rst` = 0 for 2 clocks with si = 8'hFF -> so = 8'h00 on every cycle after the first edge.
- Single load, DEPTH = 1: after reset, `rst` = 1, si = 8'b1001_0011 -> so = 8'h93 one clock later; si held -> so stays 8'h93.
- Streaming, DEPTH = 3: drive si = 8'h01, 8'h02, 8'h03 … on consecutive edges -> so shows 8'h00 for the first 3 outputs after reset, then 8'h01, 8'h02, 8'h03 in order, one per cycle.
- Reset mid-stream, DEPTH = 3: assert `rst` = 0 for 1 clock while the pipeline holds 8'hA5/8'h5A/8'h3C -> so = 8'h00 next cycle; none of those three words ever appear on `so`.
- Walking-ones/zeros, WIDTH = 8: si = 8'h01 << i, then ~(8'h01 << i), for i = 0..7 -> `so` matches `si` delayed by DEPTH on all bits, confirming no stuck or swapped bits.
- PIPO_CE_EN: load 8'h93, drop `ce` to 0 and change si to 8'h6C -> so holds 8'h93; assert `rst` = 0 with `ce` = 0 -> so = 8'h00; raise `ce` -> so = 8'h6C after DEPTH clocks.
